// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 measurement/setpoint word and the ASCII setpoint parser.
package dht11_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_MINUS = 8'h2d;
  localparam logic [7:0] ASCII_DOT   = 8'h2e;
  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_H     = 8'h48;
  localparam logic [7:0] ASCII_CR    = 8'h0d;
  localparam logic [7:0] ASCII_LF    = 8'h0a;

  // Field positions of the packed word, identical for readings and setpoints.
  localparam int SP_H_INT_MSB  = 31;
  localparam int SP_H_INT_LSB  = 24;
  localparam int SP_H_FRAC_MSB = 23;
  localparam int SP_H_FRAC_LSB = 16;
  localparam int SP_T_INT_MSB  = 15;
  localparam int SP_T_INT_LSB  = 8;
  localparam int SP_T_SIGN     = 7;
  localparam int SP_T_FRAC_MSB = 6;
  localparam int SP_T_FRAC_LSB = 0;

  typedef enum logic [2:0] {
    PS_IDLE,
    PS_SIGN,
    PS_INT_FIRST,
    PS_INT,
    PS_FRAC,
    PS_FRAC_DONE,
    PS_SKIP
  } parse_state_t;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] value;
  } digit_t;

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII byte to decimal digit decode; value is 0 for non-digits.
module ascii_digit_decode
  import dht11_pkg::*;
(
  input  logic [7:0] code,
  output digit_t     dig
);

  always_comb begin
    dig          = '0;
    dig.is_digit = (code >= ASCII_0) && (code <= ASCII_9);
    if (dig.is_digit) dig.value = code[3:0];
  end

endmodule

// File: rtl/dht11_setpoint_parser.sv
// Parses ASCII "T-12.3" / "H45" command lines from the UART RX strobe into the
// packed DHT11-layout setpoint word.
module dht11_setpoint_parser
  import dht11_pkg::*;
#(
  parameter int MAX_INT_DIGITS = 3,
  parameter int INT_LIMIT      = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] setpoint,
  output logic        setpoint_valid,
  output logic        parse_err
);

  localparam int                CNT_W   = $clog2(MAX_INT_DIGITS + 2);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_INT_DIGITS);
  localparam logic [13:0]       LIMIT_W = 14'(INT_LIMIT);

  parse_state_t     state;
  logic             is_temp;
  logic             neg;
  logic             ovf;
  logic [9:0]       acc;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       frac;

  digit_t           dig;
  logic             is_term;
  logic [13:0]      acc_next_w;
  logic [CNT_W-1:0] cnt_inc;
  logic             do_commit;
  logic             do_abort;
  logic             sign_bit;

  ascii_digit_decode u_dec (
    .code (rx_data),
    .dig  (dig)
  );

  // Overflow is judged on the unwrapped product so the 10-bit accumulator may wrap freely.
  assign acc_next_w = 14'(acc) * 14'd10 + 14'(dig.value);
  assign cnt_inc    = cnt + CNT_W'(1);
  assign is_term    = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
  assign do_commit  = rx_valid && is_term && ((state == PS_INT) || (state == PS_FRAC_DONE));
  assign do_abort   = rx_valid && is_term &&
                      ((state == PS_SIGN) || (state == PS_INT_FIRST) ||
                       (state == PS_FRAC) || (state == PS_SKIP));
  assign sign_bit   = neg && ((acc != '0) || (frac != '0));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= PS_IDLE;
      is_temp        <= 1'b0;
      neg            <= 1'b0;
      ovf            <= 1'b0;
      acc            <= '0;
      cnt            <= '0;
      frac           <= '0;
      setpoint       <= '0;
      setpoint_valid <= 1'b0;
      parse_err      <= 1'b0;
    end else begin
      setpoint_valid <= 1'b0;
      parse_err      <= 1'b0;

      if (do_abort) begin
        parse_err <= 1'b1;
      end else if (do_commit) begin
        if (ovf) begin
          parse_err <= 1'b1;
        end else begin
          setpoint_valid <= 1'b1;
          if (is_temp) begin
            setpoint[SP_T_INT_MSB:SP_T_INT_LSB]   <= acc[7:0];
            setpoint[SP_T_SIGN]                   <= sign_bit;
            setpoint[SP_T_FRAC_MSB:SP_T_FRAC_LSB] <= {3'b000, frac};
          end else begin
            setpoint[SP_H_INT_MSB:SP_H_INT_LSB]   <= acc[7:0];
            setpoint[SP_H_FRAC_MSB:SP_H_FRAC_LSB] <= {4'b0000, frac};
          end
        end
      end

      if (rx_valid) begin
        case (state)
          PS_IDLE: begin
            if ((rx_data == ASCII_T) || (rx_data == ASCII_H)) begin
              is_temp <= (rx_data == ASCII_T);
              neg     <= 1'b0;
              ovf     <= 1'b0;
              acc     <= '0;
              cnt     <= '0;
              frac    <= '0;
              state   <= PS_SIGN;
            end else if (!is_term) begin
              state <= PS_SKIP;
            end
          end
          PS_SIGN, PS_INT_FIRST: begin
            if ((state == PS_SIGN) && (rx_data == ASCII_MINUS) && is_temp) begin
              neg   <= 1'b1;
              state <= PS_INT_FIRST;
            end else if (dig.is_digit) begin
              acc   <= 10'(dig.value);
              cnt   <= CNT_W'(1);
              if (14'(dig.value) > LIMIT_W) ovf <= 1'b1;
              state <= PS_INT;
            end else begin
              state <= is_term ? PS_IDLE : PS_SKIP;
            end
          end
          PS_INT: begin
            if (dig.is_digit) begin
              acc <= acc_next_w[9:0];
              if (cnt <= MAX_CNT) cnt <= cnt_inc;
              if ((cnt_inc > MAX_CNT) || (acc_next_w > LIMIT_W)) ovf <= 1'b1;
            end else if (rx_data == ASCII_DOT) begin
              state <= PS_FRAC;
            end else begin
              state <= is_term ? PS_IDLE : PS_SKIP;
            end
          end
          PS_FRAC: begin
            if (dig.is_digit) begin
              frac  <= dig.value;
              state <= PS_FRAC_DONE;
            end else begin
              state <= is_term ? PS_IDLE : PS_SKIP;
            end
          end
          PS_FRAC_DONE: state <= is_term ? PS_IDLE : PS_SKIP;
          PS_SKIP:      if (is_term) state <= PS_IDLE;
          default:      state <= PS_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dht11_setpoint_parser.sv
// Directed bench for dht11_setpoint_parser: hand-computed setpoint words and pulse counts.
module tb_dht11_setpoint_parser;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] setpoint;
  logic        setpoint_valid;
  logic        parse_err;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ecnt = 0;
  int both_cnt = 0;

  dht11_setpoint_parser #(.MAX_INT_DIGITS(3), .INT_LIMIT(255)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .setpoint       (setpoint),
    .setpoint_valid (setpoint_valid),
    .parse_err      (parse_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Values read here at posedge are those held during the previous cycle.
  always @(posedge sys_clk) begin
    if (setpoint_valid) vcnt++;
    if (parse_err) ecnt++;
    if (setpoint_valid && parse_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx_data  = s[i];
      rx_valid = 1'b1;
      @(negedge sys_clk);
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // last_pulse = {setpoint_valid, parse_err} expected one cycle after the final byte.
  task automatic run_line(input string tag, input string s, input logic [31:0] exp_sp,
                          input int exp_v, input int exp_e, input logic [1:0] last_pulse);
    int v0, e0;
    v0 = vcnt;
    e0 = ecnt;
    send(s);
    chk({tag, "_pulse"}, {30'd0, setpoint_valid, parse_err}, {30'd0, last_pulse});
    chk({tag, "_sp"}, setpoint, exp_sp);
    @(negedge sys_clk);
    chk({tag, "_pulse_end"}, {30'd0, setpoint_valid, parse_err}, 32'd0);
    @(negedge sys_clk);
    chk({tag, "_nvalid"}, 32'(vcnt - v0), 32'(exp_v));
    chk({tag, "_nerr"}, 32'(ecnt - e0), 32'(exp_e));
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_sp", setpoint, 32'h0);
    chk("rst_valid", {31'd0, setpoint_valid}, 32'd0);
    chk("rst_err", {31'd0, parse_err}, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    run_line("t25_5",  "T25.5\n",        32'h0000_1905, 1, 0, 2'b10);
    run_line("tm0",    "T-0\n",          32'h0000_0000, 1, 0, 2'b10);
    run_line("tm12_3", "T-12.3\015\n",   32'h0000_0C83, 1, 0, 2'b00);
    run_line("h45",    "H45\n",          32'h2D00_0C83, 1, 0, 2'b10);

    run_line("t256",   "T256\n",         32'h2D00_0C83, 0, 1, 2'b01);
    run_line("t1234",  "T1234\n",        32'h2D00_0C83, 0, 1, 2'b01);
    run_line("hm5",    "H-5\n",          32'h2D00_0C83, 0, 1, 2'b01);
    run_line("t12_34", "T12.34\n",       32'h2D00_0C83, 0, 1, 2'b01);
    run_line("t_empty","T\n",            32'h2D00_0C83, 0, 1, 2'b01);

    run_line("t255_9", "T255.9\n",       32'h2D00_FF09, 1, 0, 2'b10);
    run_line("x9_h60", "X9\nH60.0\n",    32'h3C00_FF09, 1, 1, 2'b10);

    // Partial line "T3" is cut by reset and must leave no trace.
    send("T3");
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk("midrst_sp", setpoint, 32'h0);
    chk("midrst_pulse", {30'd0, setpoint_valid, parse_err}, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    run_line("h50",    "H50\n",          32'h3200_0000, 1, 0, 2'b10);

    chk("never_both", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
